// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: widths, idle symbol, FSM states and byte-select helper
// shared by the 32-to-8 transmit and 8-to-32 receive lanes.
package pcie_phy_pkg;
   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hBC;
   typedef enum logic {IDLE, SEND} tx_state_t;
   // byte 0 is the most significant byte of the word
   function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
      logic [WORD_W-1:0] s;
      s = w << {idx, 3'b000};
      return s[WORD_W-1 -: BYTE_W];
   endfunction
endpackage

// File: rtl/m32_8_tx_if.sv
// m32_8_tx_if: word-in handshake and byte-out stream of the 32-to-8 transmitter
interface m32_8_tx_if;
   import pcie_phy_pkg::*;
   logic [WORD_W-1:0] data_input;
   logic              valid_input;
   logic              ready_out;
   logic              sinc;
   logic [BYTE_W-1:0] data_8;
   logic              valid_8;
   logic              sincout;
   modport master(output data_input, valid_input, sinc, input ready_out, data_8, valid_8, sincout);
   modport slave(input data_input, valid_input, sinc, output ready_out, data_8, valid_8, sincout);
endinterface

// File: rtl/m32_8_fifo.sv
// m32_8_fifo: 2-entry word FIFO; caller guarantees no push when full and no pop when empty.
module m32_8_fifo import pcie_phy_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] head,
   output logic [1:0]        count
);
   logic [WORD_W-1:0] mem [2];
   logic rd_ptr, wr_ptr;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
endmodule

// File: rtl/m32_8_tx.sv
// m32_8_tx: serializes buffered 32-bit words into a registered MSB-first byte stream,
// starting new words only on word boundaries while sinc is high.
module m32_8_tx import pcie_phy_pkg::*; #(
   parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
   input logic        clk_4f,
   input logic        reset,
   m32_8_tx_if.slave  bus
);
   tx_state_t state, state_nx;
   logic [1:0] idx, idx_nx, count;
   logic [WORD_W-1:0] shifter, shifter_nx, head;
   logic push, load;
   assign bus.ready_out = count != 2'd2;
   assign push = bus.valid_input && bus.ready_out;
   m32_8_fifo u_fifo (
      .clk   (clk_4f),
      .rst   (reset),
      .push  (push),
      .pop   (load),
      .din   (bus.data_input),
      .head  (head),
      .count (count)
   );
   // a new word may only start from idle or right after the last byte of the current one
   always_comb begin
      load       = count != 2'd0 && bus.sinc && (state == IDLE || idx == 2'd3);
      state_nx   = (load || (state == SEND && idx != 2'd3)) ? SEND : IDLE;
      idx_nx     = (state_nx == SEND && !load) ? idx + 2'd1 : 2'd0;
      shifter_nx = load ? head : shifter;
   end
   always_ff @(posedge clk_4f or posedge reset)
      if (reset) begin
         state       <= IDLE;
         idx         <= 2'd0;
         shifter     <= '0;
         bus.data_8  <= IDLE_BYTE;
         bus.valid_8 <= 1'b0;
         bus.sincout <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         shifter     <= shifter_nx;
         bus.data_8  <= state_nx == SEND ? word_byte(shifter_nx, idx_nx) : IDLE_BYTE;
         bus.valid_8 <= state_nx == SEND;
         bus.sincout <= bus.sinc;
      end
endmodule

// File: tb/tb_m32_8_tx.sv
// tb_m32_8_tx: table-driven byte-stream checks plus hand-written reset sequences for m32_8_tx.
module tb_m32_8_tx;
   typedef struct {
      logic        vin;
      logic [31:0] din;
      logic        sinc;
      logic        rdy;
      logic        v8;
      logic [7:0]  d8;
      logic        so;
   } vec_t;
   vec_t vq[$];
   logic clk_4f = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   m32_8_tx_if bus ();
   m32_8_tx dut (.clk_4f(clk_4f), .reset(reset), .bus(bus));
   always #5 clk_4f = ~clk_4f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic vin, input logic [31:0] din, input logic sinc,
                      input logic rdy, input logic v8, input logic [7:0] d8, input logic so);
      vq.push_back('{vin, din, sinc, rdy, v8, d8, so});
   endtask

   task automatic drive(input logic vin, input logic [31:0] din, input logic sinc);
      bus.valid_input = vin;
      bus.data_input  = din;
      bus.sinc        = sinc;
   endtask

   task automatic expect_out(input string tag, input logic rdy, input logic v8, input logic [7:0] d8, input logic so);
      check({tag, " ready"}, 32'(bus.ready_out), 32'(rdy));
      check({tag, " valid_8"}, 32'(bus.valid_8), 32'(v8));
      check({tag, " data_8"}, 32'(bus.data_8), 32'(d8));
      check({tag, " sincout"}, 32'(bus.sincout), 32'(so));
   endtask

   initial begin
      // single word
      add(1, 32'hDEADBEEF, 1, 1, 0, 8'hBC, 1);
      add(0, 0, 1, 1, 1, 8'hDE, 1);
      add(0, 0, 1, 1, 1, 8'hAD, 1);
      add(0, 0, 1, 1, 1, 8'hBE, 1);
      add(0, 0, 1, 1, 1, 8'hEF, 1);
      add(0, 0, 1, 1, 0, 8'hBC, 1);
      // back-to-back, with junk offered while full
      add(1, 32'h01020304, 1, 1, 0, 8'hBC, 1);
      add(1, 32'h05060708, 1, 1, 1, 8'h01, 1);
      add(1, 32'h090A0B0C, 1, 0, 1, 8'h02, 1);
      add(1, 32'hBAD0BAD0, 1, 0, 1, 8'h03, 1);
      add(1, 32'hBAD1BAD1, 1, 0, 1, 8'h04, 1);
      add(1, 32'hBAD2BAD2, 1, 1, 1, 8'h05, 1);
      add(0, 0, 1, 1, 1, 8'h06, 1);
      add(0, 0, 1, 1, 1, 8'h07, 1);
      add(0, 0, 1, 1, 1, 8'h08, 1);
      add(0, 0, 1, 1, 1, 8'h09, 1);
      add(0, 0, 1, 1, 1, 8'h0A, 1);
      add(0, 0, 1, 1, 1, 8'h0B, 1);
      add(0, 0, 1, 1, 1, 8'h0C, 1);
      add(0, 0, 1, 1, 0, 8'hBC, 1);
      // backpressure with sinc low
      add(1, 32'h10111213, 0, 1, 0, 8'hBC, 0);
      add(1, 32'h20212223, 0, 0, 0, 8'hBC, 0);
      add(1, 32'h30313233, 0, 0, 0, 8'hBC, 0);
      add(1, 32'h30313233, 1, 1, 1, 8'h10, 1);
      add(1, 32'h30313233, 1, 0, 1, 8'h11, 1);
      add(0, 0, 1, 0, 1, 8'h12, 1);
      add(0, 0, 1, 0, 1, 8'h13, 1);
      add(0, 0, 1, 1, 1, 8'h20, 1);
      add(0, 0, 1, 1, 1, 8'h21, 1);
      add(0, 0, 1, 1, 1, 8'h22, 1);
      add(0, 0, 1, 1, 1, 8'h23, 1);
      add(0, 0, 1, 1, 1, 8'h30, 1);
      add(0, 0, 1, 1, 1, 8'h31, 1);
      add(0, 0, 1, 1, 1, 8'h32, 1);
      add(0, 0, 1, 1, 1, 8'h33, 1);
      add(0, 0, 1, 1, 0, 8'hBC, 1);
      // sinc drop mid-word with a second word queued
      add(1, 32'hA1B2C3D4, 1, 1, 0, 8'hBC, 1);
      add(1, 32'hE5F60718, 1, 1, 1, 8'hA1, 1);
      add(0, 0, 1, 1, 1, 8'hB2, 1);
      add(0, 0, 0, 1, 1, 8'hC3, 0);
      add(0, 0, 0, 1, 1, 8'hD4, 0);
      add(0, 0, 0, 1, 0, 8'hBC, 0);
      add(0, 0, 0, 1, 0, 8'hBC, 0);
      add(0, 0, 1, 1, 1, 8'hE5, 1);
      add(0, 0, 1, 1, 1, 8'hF6, 1);
      add(0, 0, 1, 1, 1, 8'h07, 1);
      add(0, 0, 1, 1, 1, 8'h18, 1);
      add(0, 0, 1, 1, 0, 8'hBC, 1);

      drive(0, 0, 0);
      repeat (2) @(negedge clk_4f);
      expect_out("reset", 1, 0, 8'hBC, 0);
      reset = 1'b0;
      foreach (vq[i]) begin
         drive(vq[i].vin, vq[i].din, vq[i].sinc);
         @(negedge clk_4f);
         expect_out($sformatf("v%0d", i), vq[i].rdy, vq[i].v8, vq[i].d8, vq[i].so);
      end

      // reset during byte 1 with a second word still buffered
      drive(1, 32'h11223344, 1);
      @(negedge clk_4f);
      drive(1, 32'h99AABBCC, 1);
      @(negedge clk_4f);
      expect_out("rst_pre0", 1, 1, 8'h11, 1);
      drive(0, 0, 1);
      @(negedge clk_4f);
      expect_out("rst_pre1", 1, 1, 8'h22, 1);
      #2 reset = 1'b1;
      #1 expect_out("rst_async", 1, 0, 8'hBC, 0);
      @(negedge clk_4f);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk_4f);
         expect_out("rst_idle", 1, 0, 8'hBC, 1);
      end
      drive(1, 32'h55667788, 1);
      @(negedge clk_4f);
      expect_out("rst_push", 1, 0, 8'hBC, 1);
      drive(0, 0, 1);
      for (int k = 0; k < 5; k++) begin
         logic [39:0] exp_bytes;
         exp_bytes = 40'h55667788BC;
         @(negedge clk_4f);
         expect_out($sformatf("rst_post%0d", k), 1, k < 4, exp_bytes[39-8*k -: 8], 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
